// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the PGA gain-link SPI receiver.
// Optional readback: define SPI_RX_ECHO_EN to add the sdo echo port.
package spi_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } rx_state_t;

  localparam int SPI_DW_DEFAULT   = 8;
  localparam int SPI_SYNC_DEFAULT = 2;

endpackage

// File: rtl/spi_gain_receiver_sync_edge_detect.sv
// Multi-flop synchronizer for one async input, plus
// single-cycle rise/fall pulses on the synced level.
module sync_edge_detect
  import spi_rx_pkg::*;
#(
  parameter int   STAGES  = SPI_SYNC_DEFAULT,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Shift the pin through the chain; keep a delayed copy for edges
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
    prev_d = sync_q[STAGES-1];
  end

  // Synchronizer and delay registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/spi_gain_receiver.sv
// SPI responder deserializer for the PGA gain link.
// Define SPI_RX_ECHO_EN to echo the previous word on sdo.
module spi_gain_receiver
  import spi_rx_pkg::*;
#(
  parameter int DW          = SPI_DW_DEFAULT,
  parameter int SYNC_STAGES = SPI_SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sck,
  input  logic          cs_n,
  input  logic          sdi,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          frame_err_o,
  output logic          busy_o
`ifdef SPI_RX_ECHO_EN
  ,
  output logic          sdo
`endif
);

  localparam int CW = $clog2(DW + 2);
  localparam logic [CW-1:0] CNT_DW  = CW'(DW);
  localparam logic [CW-1:0] CNT_MAX = CW'(DW + 1);

  logic sck_lvl;
  logic sck_rise;
  logic sck_fall;
  logic cs_lvl;
  logic cs_rise;
  logic cs_fall;
  logic unused_lvl;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b0)
  ) u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (sck),
    .q_o   (sck_lvl),
    .rise_o(sck_rise),
    .fall_o(sck_fall)
  );

  // cs_n idles high, so its synchronizer resets to 1
  sync_edge_detect #(
    .STAGES (SYNC_STAGES),
    .RST_VAL(1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (cs_n),
    .q_o   (cs_lvl),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  logic [SYNC_STAGES-1:0] sdi_sync_q;
  logic [SYNC_STAGES-1:0] sdi_sync_d;
  logic                   sdi_s;

  // sdi needs only a level; its edges carry no meaning
  always_comb begin
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};
  end

  // sdi synchronizer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sdi_sync_q <= '1;
    end else begin
      sdi_sync_q <= sdi_sync_d;
    end
  end

  assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

  rx_state_t      state_q;
  rx_state_t      state_d;
  logic [DW-1:0]  shift_q;
  logic [DW-1:0]  shift_d;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_d;
  logic [DW-1:0]  data_q;
  logic [DW-1:0]  data_d;
  logic           valid_q;
  logic           valid_d;
  logic           ferr_q;
  logic           ferr_d;

  // Frame FSM: cs deassertion wins over a same-cycle sck edge
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = SHIFT;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = DONE;
        end else if (sck_rise) begin
          shift_d = {shift_q[DW-2:0], sdi_s};
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        if (cnt_q == CNT_DW) begin
          data_d  = shift_q;
          valid_d = 1'b1;
        end else begin
          ferr_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame state, shifter and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q == SHIFT);

`ifdef SPI_RX_ECHO_EN
  logic [DW-1:0] echo_q;
  logic [DW-1:0] echo_d;
  logic          sdo_q;
  logic          sdo_d;

  // Load the held word at frame start, then shift on each sck fall
  always_comb begin
    echo_d = echo_q;
    sdo_d  = sdo_q;
    if (state_q == IDLE && cs_fall) begin
      sdo_d  = data_q[DW-1];
      echo_d = {data_q[DW-2:0], 1'b0};
    end else if (state_q == SHIFT && !cs_rise && sck_fall) begin
      sdo_d  = echo_q[DW-1];
      echo_d = {echo_q[DW-2:0], 1'b0};
    end
  end

  // Echo shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      echo_q <= '0;
      sdo_q  <= 1'b1;
    end else begin
      echo_q <= echo_d;
      sdo_q  <= sdo_d;
    end
  end

  assign sdo        = (state_q == SHIFT) ? sdo_q : 1'b1;
  assign unused_lvl = sck_lvl ^ cs_lvl;
`else
  assign unused_lvl = sck_lvl ^ cs_lvl ^ sck_fall;
`endif

endmodule

// File: tb/tb_spi_gain_receiver.sv
// Directed bench for spi_gain_receiver.
// Echo checks run only when SPI_RX_ECHO_EN is defined.
module tb_spi_gain_receiver;

  logic       clk;
  logic       rst_n;
  logic       sck;
  logic       cs_n;
  logic       sdi;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       busy_o;
`ifdef SPI_RX_ECHO_EN
  logic       sdo;
`endif

  int errors = 0;
  int checks = 0;
  int vcnt   = 0;
  int fcnt   = 0;
  logic [15:0] rx_echo;

  spi_gain_receiver #(
    .DW         (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sck        (sck),
    .cs_n       (cs_n),
    .sdi        (sdi),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .frame_err_o(frame_err_o),
    .busy_o     (busy_o)
`ifdef SPI_RX_ECHO_EN
    ,
    .sdo        (sdo)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Count high cycles of each pulse; they must never coincide
  always @(negedge clk) begin
    if (valid_o === 1'b1) vcnt++;
    if (frame_err_o === 1'b1) fcnt++;
    if (valid_o === 1'b1 || frame_err_o === 1'b1)
      chk("pulse_excl", {31'd0, valid_o & frame_err_o}, 32'd0);
  end

  task automatic start_frame();
    cs_n = 1'b0;
    rx_echo = '0;
    #40;
  endtask

  task automatic shift_bits(input logic [15:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sck = 1'b0;
      sdi = w[i];
      #40;
      sck = 1'b1;
`ifdef SPI_RX_ECHO_EN
      rx_echo = {rx_echo[14:0], sdo};
`endif
      #40;
    end
  endtask

  task automatic end_frame();
    sck = 1'b0;
    #40;
    cs_n = 1'b1;
    sdi = 1'b1;
  endtask

  task automatic frame(input logic [15:0] w, input int n);
    start_frame();
    shift_bits(w, n);
    end_frame();
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    cs_n  = 1'b1;
    sdi   = 1'b1;
    #12;
    chk("rst_data",  {24'd0, data_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ferr",  {31'd0, frame_err_o}, 32'd0);
    chk("rst_busy",  {31'd0, busy_o}, 32'd0);
`ifdef SPI_RX_ECHO_EN
    chk("rst_sdo",   {31'd0, sdo}, 32'd1);
`endif
    #10;
    rst_n = 1'b1;
    #40;

    // 1: single frame A5
    start_frame();
    chk("t1_busy", {31'd0, busy_o}, 32'd1);
    shift_bits(16'h00A5, 8);
    end_frame();
    #100;
    chk("t1_data",  {24'd0, data_o}, 32'hA5);
    chk("t1_vcnt",  vcnt, 32'd1);
    chk("t1_fcnt",  fcnt, 32'd0);
    chk("t1_idle",  {31'd0, busy_o}, 32'd0);

    // 2: back-to-back 00 then FF, 8 clk gap
    frame(16'h0000, 8);
    #70;
    chk("t2_data0", {24'd0, data_o}, 32'h00);
    #10;
    frame(16'h00FF, 8);
    #100;
    chk("t2_data1", {24'd0, data_o}, 32'hFF);
    chk("t2_vcnt",  vcnt, 32'd3);
    chk("t2_fcnt",  fcnt, 32'd0);

    // 3: short 5-bit frame, then long 9-bit frame
    frame(16'h0015, 5);
    #100;
    chk("t3_short_f", fcnt, 32'd1);
    frame(16'h0155, 9);
    #100;
    chk("t3_long_f",  fcnt, 32'd2);
    chk("t3_vcnt",    vcnt, 32'd3);
    chk("t3_data",    {24'd0, data_o}, 32'hFF);

    // 4: reset after 4 bits of 3C, then full C3
    start_frame();
    shift_bits(16'h0003, 4);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    sck   = 1'b0;
    sdi   = 1'b1;
    #1;
    chk("t4_rdata",  {24'd0, data_o}, 32'd0);
    chk("t4_rvalid", {31'd0, valid_o}, 32'd0);
    chk("t4_rferr",  {31'd0, frame_err_o}, 32'd0);
    chk("t4_rbusy",  {31'd0, busy_o}, 32'd0);
    #19;
    rst_n = 1'b1;
    #100;
    chk("t4_nopulse_v", vcnt, 32'd3);
    chk("t4_nopulse_f", fcnt, 32'd2);
    frame(16'h00C3, 8);
    #100;
    chk("t4_data", {24'd0, data_o}, 32'hC3);
    chk("t4_vcnt", vcnt, 32'd4);

    // 5: sck with cs_n high, then cs_n pulse with no sck
    for (int i = 0; i < 4; i++) begin
      sck = 1'b1;
      #40;
      sck = 1'b0;
      #40;
    end
    #60;
    chk("t5_idle_f", fcnt, 32'd2);
    chk("t5_idle_b", {31'd0, busy_o}, 32'd0);
    cs_n = 1'b0;
    #100;
    cs_n = 1'b1;
    #100;
    chk("t5_vcnt", vcnt, 32'd4);
    chk("t5_fcnt", fcnt, 32'd3);
    chk("t5_data", {24'd0, data_o}, 32'hC3);

`ifdef SPI_RX_ECHO_EN
    // 6: echo of the previously held word
    frame(16'h005A, 8);
    chk("t6_echo0", {16'd0, rx_echo}, 32'h00C3);
    #100;
    chk("t6_data0", {24'd0, data_o}, 32'h5A);
    frame(16'h0096, 8);
    chk("t6_echo1", {16'd0, rx_echo}, 32'h005A);
    #100;
    chk("t6_data1", {24'd0, data_o}, 32'h96);
    chk("t6_sdo_idle", {31'd0, sdo}, 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
